enemy_slot_compactor: RTL and testbench

Frame-synchronous adapter between the fly sprite table and the enemy render/collision slots. It generalises the fixed 17-entry, 10-bit pass-through to parametrised source count, destination slot count and coordinate width. On each frame tick it snapshots the source table, scans it one entry per clock, and packs the alive entries into the lowest destination slots. It then commits the result atomically, so downstream logic never sees a half-updated table. It sits between the fly movement logic and the renderer/collision checker.

---
 rtl/enemy_slot_compactor.sv | 176 +++++++++++++++++
 tb/tb_enemy_slot_compactor.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_slot_compactor.sv
// Frame-synchronous compactor: snapshots the fly sprite table on frame_tick, scans one entry
// per clock, packs alive entries into the lowest enemy slots and commits them in one cycle.
module enemy_slot_compactor #(
   parameter int N_SRC   = 17,
   parameter int N_DST   = 8,
   parameter int COORD_W = 10,
   localparam int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1,
   localparam int CNT_W  = $clog2(N_SRC + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       frame_tick,
   input  logic [N_SRC*COORD_W-1:0]   src_x_flat,
   input  logic [N_SRC*COORD_W-1:0]   src_y_flat,
   input  logic [N_SRC-1:0]           src_alive,
   output logic [N_DST*COORD_W-1:0]   enemy_x_flat,
   output logic [N_DST*COORD_W-1:0]   enemy_y_flat,
   output logic [N_DST-1:0]           enemy_alive,
   output logic [N_DST*IDX_W-1:0]     enemy_src_idx,
   output logic [CNT_W-1:0]           alive_count,
   output logic                       overflow,
   output logic                       busy
);

   localparam int WR_W = (N_DST > 1) ? $clog2(N_DST + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCAN   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_next;
   logic [N_SRC*COORD_W-1:0]   r_snap_x;
   logic [N_SRC*COORD_W-1:0]   r_snap_y;
   logic [N_SRC-1:0]           r_snap_alive;
   logic [N_DST*COORD_W-1:0]   r_sh_x;
   logic [N_DST*COORD_W-1:0]   r_sh_y;
   logic [N_DST-1:0]           r_sh_alive;
   logic [N_DST*IDX_W-1:0]     r_sh_idx;
   logic [IDX_W-1:0]           r_idx;
   logic [WR_W-1:0]            r_wr;
   logic [CNT_W-1:0]           r_cnt;
   logic [N_DST*COORD_W-1:0]   r_ex;
   logic [N_DST*COORD_W-1:0]   r_ey;
   logic [N_DST-1:0]           r_ealive;
   logic [N_DST*IDX_W-1:0]     r_eidx;
   logic [CNT_W-1:0]           r_acount;
   logic                       r_ovf;
   logic                       r_busy;
   logic [COORD_W-1:0]         w_cur_x;
   logic [COORD_W-1:0]         w_cur_y;
   logic                       w_cur_alive;
   logic                       w_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (frame_tick) w_next = S_SCAN;
            else            w_next = S_IDLE;
         end
         S_SCAN: begin
            if (r_idx == IDX_W'(N_SRC - 1)) w_next = S_COMMIT;
            else                            w_next = S_SCAN;
         end
         S_COMMIT: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // select the snapshot entry under the scan index
   always_comb begin
      w_cur_x     = '0;
      w_cur_y     = '0;
      w_cur_alive = 1'b0;
      for (int j = 0; j < N_SRC; j++) begin
         if (r_idx == IDX_W'(j)) begin
            w_cur_x     = r_snap_x[j*COORD_W +: COORD_W];
            w_cur_y     = r_snap_y[j*COORD_W +: COORD_W];
            w_cur_alive = r_snap_alive[j];
         end
      end
   end

   assign w_take = w_cur_alive && (r_wr < WR_W'(N_DST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap_x     <= '0;
         r_snap_y     <= '0;
         r_snap_alive <= '0;
         r_sh_x       <= '0;
         r_sh_y       <= '0;
         r_sh_alive   <= '0;
         r_sh_idx     <= '0;
         r_idx        <= '0;
         r_wr         <= '0;
         r_cnt        <= '0;
         r_ex         <= '0;
         r_ey         <= '0;
         r_ealive     <= '0;
         r_eidx       <= '0;
         r_acount     <= '0;
         r_ovf        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (frame_tick) begin
                  r_snap_x     <= src_x_flat;
                  r_snap_y     <= src_y_flat;
                  r_snap_alive <= src_alive;
                  r_sh_x       <= '0;
                  r_sh_y       <= '0;
                  r_sh_alive   <= '0;
                  r_sh_idx     <= '0;
                  r_idx        <= '0;
                  r_wr         <= '0;
                  r_cnt        <= '0;
               end
            end
            S_SCAN: begin
               // entries beyond the last slot are only counted, never written
               if (w_take) begin
                  for (int k = 0; k < N_DST; k++) begin
                     if (r_wr == WR_W'(k)) begin
                        r_sh_x[k*COORD_W +: COORD_W] <= w_cur_x;
                        r_sh_y[k*COORD_W +: COORD_W] <= w_cur_y;
                        r_sh_idx[k*IDX_W +: IDX_W]   <= r_idx;
                        r_sh_alive[k]                <= 1'b1;
                     end
                  end
                  r_wr <= r_wr + WR_W'(1);
               end
               if (w_cur_alive) r_cnt <= r_cnt + CNT_W'(1);
               if (r_idx != IDX_W'(N_SRC - 1)) r_idx <= r_idx + IDX_W'(1);
            end
            S_COMMIT: begin
               r_ex     <= r_sh_x;
               r_ey     <= r_sh_y;
               r_ealive <= r_sh_alive;
               r_eidx   <= r_sh_idx;
               r_acount <= r_cnt;
               r_ovf    <= (32'(r_cnt) > 32'(N_DST));
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= (w_next != S_IDLE);
      end
   end

   assign enemy_x_flat  = r_ex;
   assign enemy_y_flat  = r_ey;
   assign enemy_alive   = r_ealive;
   assign enemy_src_idx = r_eidx;
   assign alive_count   = r_acount;
   assign overflow      = r_ovf;
   assign busy          = r_busy;

endmodule

// File: tb/tb_enemy_slot_compactor.sv
// Scoreboard bench: three parameterisations, expectations computed from a list-based model
// at tick time, compared by per-instance monitors when busy falls (commit).
module tb_enemy_slot_compactor;

   typedef struct packed {
      logic [203:0] x;
      logic [203:0] y;
      logic [84:0]  idx;
      logic [16:0]  al;
      logic [4:0]   cnt;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int   src_x[17];
   int   src_y[17];
   logic [16:0] src_al;

   // A: 17 -> 8, 10-bit
   logic         a_tick = 1'b0;
   logic [169:0] a_sx, a_sy;
   logic [79:0]  a_ex, a_ey;
   logic [7:0]   a_al;
   logic [39:0]  a_idx;
   logic [4:0]   a_cnt;
   logic         a_ovf, a_busy;
   // B: 17 -> 17, 12-bit
   logic         b_tick = 1'b0;
   logic [203:0] b_sx, b_sy, b_ex, b_ey;
   logic [16:0]  b_al;
   logic [84:0]  b_idx;
   logic [4:0]   b_cnt;
   logic         b_ovf, b_busy;
   // C: 1 -> 8, 10-bit
   logic         c_tick = 1'b0;
   logic [9:0]   c_sx, c_sy;
   logic [79:0]  c_ex, c_ey;
   logic [7:0]   c_al;
   logic [7:0]   c_idx;
   logic [0:0]   c_cnt;
   logic         c_ovf, c_busy;

   always_comb begin
      for (int i = 0; i < 17; i++) begin
         a_sx[i*10 +: 10] = 10'(src_x[i]);
         a_sy[i*10 +: 10] = 10'(src_y[i]);
         b_sx[i*12 +: 12] = 12'(src_x[i]);
         b_sy[i*12 +: 12] = 12'(src_y[i]);
      end
      c_sx = 10'(src_x[0]);
      c_sy = 10'(src_y[0]);
   end

   enemy_slot_compactor #(.N_SRC(17), .N_DST(8), .COORD_W(10)) u_a (
      .clk(clk), .rst_n(rst_n), .frame_tick(a_tick),
      .src_x_flat(a_sx), .src_y_flat(a_sy), .src_alive(src_al),
      .enemy_x_flat(a_ex), .enemy_y_flat(a_ey), .enemy_alive(a_al),
      .enemy_src_idx(a_idx), .alive_count(a_cnt), .overflow(a_ovf), .busy(a_busy));

   enemy_slot_compactor #(.N_SRC(17), .N_DST(17), .COORD_W(12)) u_b (
      .clk(clk), .rst_n(rst_n), .frame_tick(b_tick),
      .src_x_flat(b_sx), .src_y_flat(b_sy), .src_alive(src_al),
      .enemy_x_flat(b_ex), .enemy_y_flat(b_ey), .enemy_alive(b_al),
      .enemy_src_idx(b_idx), .alive_count(b_cnt), .overflow(b_ovf), .busy(b_busy));

   enemy_slot_compactor #(.N_SRC(1), .N_DST(8), .COORD_W(10)) u_c (
      .clk(clk), .rst_n(rst_n), .frame_tick(c_tick),
      .src_x_flat(c_sx), .src_y_flat(c_sy), .src_alive(src_al[0:0]),
      .enemy_x_flat(c_ex), .enemy_y_flat(c_ey), .enemy_alive(c_al),
      .enemy_src_idx(c_idx), .alive_count(c_cnt), .overflow(c_ovf), .busy(c_busy));

   int   errors = 0;
   int   checks = 0;
   exp_t qa[$], qb[$], qc[$];

   task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   // reference: list of alive indices, first nd of them fill the slots in order
   function automatic exp_t model(int ns, int nd, int cw);
      exp_t e;
      int   q[$];
      int   mask;
      e    = '0;
      mask = (1 << cw) - 1;
      for (int i = 0; i < ns; i++)
         if (src_al[i]) q.push_back(i);
      for (int k = 0; k < q.size() && k < nd; k++) begin
         e.x[k*12 +: 12]  = 12'(src_x[q[k]] & mask);
         e.y[k*12 +: 12]  = 12'(src_y[q[k]] & mask);
         e.idx[k*5 +: 5]  = 5'(q[k]);
         e.al[k]          = 1'b1;
      end
      e.cnt = 5'(q.size());
      e.ovf = (q.size() > nd);
      return e;
   endfunction

   task automatic cmp_frame(string t, exp_t g, exp_t e);
      chk({t, "_x"},     256'(g.x),   256'(e.x));
      chk({t, "_y"},     256'(g.y),   256'(e.y));
      chk({t, "_idx"},   256'(g.idx), 256'(e.idx));
      chk({t, "_alive"}, 256'(g.al),  256'(e.al));
      chk({t, "_count"}, 256'(g.cnt), 256'(e.cnt));
      chk({t, "_ovf"},   256'(g.ovf), 256'(e.ovf));
   endtask

   task automatic no_exp(string t);
      checks++;
      errors++;
      $display("FAIL %s_unexpected_commit got=commit expected=none", t);
   endtask

   bit   a_prev, b_prev, c_prev;
   int   a_bl, b_bl, c_bl;
   exp_t ga, gb, gc;

   always @(negedge clk) begin
      if (!rst_n) begin
         a_prev = 1'b0; a_bl = 0;
      end else begin
         if (a_busy) a_bl++;
         if (a_prev && !a_busy) begin
            chk("a_busy_len", 256'(a_bl), 256'(18));
            if (qa.size() == 0) no_exp("a");
            else begin
               ga = '0;
               for (int k = 0; k < 8; k++) begin
                  ga.x[k*12 +: 12] = 12'(a_ex[k*10 +: 10]);
                  ga.y[k*12 +: 12] = 12'(a_ey[k*10 +: 10]);
                  ga.idx[k*5 +: 5] = a_idx[k*5 +: 5];
                  ga.al[k]         = a_al[k];
               end
               ga.cnt = a_cnt;
               ga.ovf = a_ovf;
               cmp_frame("a", ga, qa.pop_front());
            end
            a_bl = 0;
         end
         a_prev = a_busy;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         b_prev = 1'b0; b_bl = 0;
      end else begin
         if (b_busy) b_bl++;
         if (b_prev && !b_busy) begin
            chk("b_busy_len", 256'(b_bl), 256'(18));
            if (qb.size() == 0) no_exp("b");
            else begin
               gb = '0;
               gb.x   = b_ex;
               gb.y   = b_ey;
               gb.idx = b_idx;
               gb.al  = b_al;
               gb.cnt = b_cnt;
               gb.ovf = b_ovf;
               cmp_frame("b", gb, qb.pop_front());
            end
            b_bl = 0;
         end
         b_prev = b_busy;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         c_prev = 1'b0; c_bl = 0;
      end else begin
         if (c_busy) c_bl++;
         if (c_prev && !c_busy) begin
            chk("c_busy_len", 256'(c_bl), 256'(2));
            if (qc.size() == 0) no_exp("c");
            else begin
               gc = '0;
               for (int k = 0; k < 8; k++) begin
                  gc.x[k*12 +: 12] = 12'(c_ex[k*10 +: 10]);
                  gc.y[k*12 +: 12] = 12'(c_ey[k*10 +: 10]);
                  gc.idx[k*5 +: 5] = 5'(c_idx[k]);
                  gc.al[k]         = c_al[k];
               end
               gc.cnt = 5'(c_cnt);
               gc.ovf = c_ovf;
               cmp_frame("c", gc, qc.pop_front());
            end
            c_bl = 0;
         end
         c_prev = c_busy;
      end
   end

   function automatic logic busy_of(int d);
      case (d)
         0:       return a_busy;
         1:       return b_busy;
         default: return c_busy;
      endcase
   endfunction

   task automatic wait_idle(int d);
      int n = 0;
      while (busy_of(d) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (busy_of(d)) begin
         checks++;
         errors++;
         $display("FAIL timeout_dut%0d got=busy expected=idle", d);
      end
   endtask

   task automatic frame(int d);
      @(negedge clk);
      case (d)
         0:       begin qa.push_back(model(17, 8, 10));  a_tick = 1'b1; end
         1:       begin qb.push_back(model(17, 17, 12)); b_tick = 1'b1; end
         default: begin qc.push_back(model(1, 8, 10));   c_tick = 1'b1; end
      endcase
      @(negedge clk);
      a_tick = 1'b0; b_tick = 1'b0; c_tick = 1'b0;
      wait_idle(d);
   endtask

   task automatic set_lin(logic [16:0] al);
      for (int i = 0; i < 17; i++) begin
         src_x[i] = i * 10;
         src_y[i] = i * 20;
      end
      src_al = al;
   endtask

   task automatic set_rand();
      int dens = $urandom_range(0, 100);
      for (int i = 0; i < 17; i++) begin
         src_x[i]  = int'($urandom_range(0, 4095));
         src_y[i]  = int'($urandom_range(0, 4095));
         src_al[i] = ($urandom_range(0, 99) < dens);
      end
   endtask

   task automatic check_a_zero(string nm);
      chk(nm, 256'({a_ex, a_ey, a_al, a_idx, a_cnt, a_ovf, a_busy}), 256'(0));
   endtask

   initial begin
      set_lin(17'h0);
      repeat (3) @(negedge clk);
      check_a_zero("reset_outputs");
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      set_lin(17'h0);                      frame(0);   // all dead
      set_lin(17'h10009);                  frame(0);   // sparse 0,3,16
      set_lin(17'h1FFFF);                  frame(0);   // all alive -> overflow
      set_lin(17'h00120);                  frame(0);   // two alive clears overflow
      set_lin(17'h000FF);                  frame(0);   // exactly N_DST alive
      set_lin(17'h100FF);                  frame(0);   // N_DST+1 alive
      for (int r = 0; r < 20; r++) begin
         set_rand();
         frame(0);
      end

      // snapshot isolation and ignored tick while busy
      set_rand();
      @(negedge clk);
      qa.push_back(model(17, 8, 10));
      a_tick = 1'b1;
      @(negedge clk);
      a_tick = 1'b0;
      repeat (2) @(negedge clk);
      set_rand();
      repeat (2) @(negedge clk);
      a_tick = 1'b1;
      @(negedge clk);
      a_tick = 1'b0;
      wait_idle(0);
      repeat (20) @(negedge clk);
      chk("ignored_tick_busy", 256'(a_busy), 256'(0));
      chk("ignored_tick_queue", 256'(qa.size()), 256'(0));

      // reset in the middle of a scan
      set_lin(17'h10009);
      frame(0);
      @(negedge clk);
      a_tick = 1'b1;
      @(negedge clk);
      a_tick = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      void'(qa.pop_back());
      #1 check_a_zero("reset_midscan_async");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (25) @(negedge clk);
      check_a_zero("reset_release_idle");

      // 17 -> 17, 12-bit
      set_lin(17'h1FFFF);                  frame(1);
      for (int r = 0; r < 5; r++) begin
         set_rand();
         frame(1);
      end

      // single source
      set_lin(17'h00001); src_x[0] = 777; src_y[0] = 345; frame(2);
      set_lin(17'h00000);                  frame(2);
      for (int r = 0; r < 4; r++) begin
         set_rand();
         frame(2);
      end

      repeat (3) @(negedge clk);
      chk("leftover_a", 256'(qa.size()), 256'(0));
      chk("leftover_b", 256'(qb.size()), 256'(0));
      chk("leftover_c", 256'(qc.size()), 256'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
